// File: rtl/mem_responder_pkg.sv
// ============================================================================
// mem_responder_pkg : shared state encoding and sizing constants
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_responder_pkg;

  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_responder_if.sv
// ============================================================================
// mem_responder_if : request/response handshake bundle for the data port
// Revision 1.0
// ============================================================================
`default_nettype none

interface mem_responder_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_write;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_write
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_write
  );

endinterface

`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
// ============================================================================
// mem_array : word storage, synchronous write, combinational read, no reset
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_array #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input  wire logic                  clk,
  input  wire logic                  i_we,
  input  wire logic [ADDR_WIDTH-1:0] i_addr,
  input  wire logic [DATA_WIDTH-1:0] i_wdata,
  output logic      [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_addr];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : single-outstanding load/store responder with wait states
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mem_responder_if.slave bus
);

  localparam int LAT_EFF = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  resp_write_q, resp_write_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Reset gates the write so a store landing on the reset edge is dropped.
  assign mem_we = (state_q == WAIT) && (cnt_q == '0) && write_q && !reset;

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (mem_we),
    .i_addr  (addr_q),
    .i_wdata (wdata_q),
    .o_rdata (mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_write_d = resp_write_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LAT_EFF);
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = RESP;
          rdata_d      = write_q ? wdata_q : mem_rdata;
          resp_write_d = write_q;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next state.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_write_q <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_write_q <= resp_write_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_write = resp_write_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : randomized self-checking bench, LATENCY=2 and LATENCY=0
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Index 0 drives the LATENCY=2 instance, index 1 the LATENCY=0 instance.
  logic [1:0]       req_valid, req_write, resp_ready;
  logic [1:0][6:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  wire  [1:0]       o_ready, o_valid, o_rwrite;
  wire  [1:0][31:0] o_rdata;

  mem_responder_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) if_lat2 ();
  mem_responder_if #(.ADDR_WIDTH(7), .DATA_WIDTH(32)) if_lat0 ();

  mem_responder #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .LATENCY(2)) u_dut_lat2 (
    .clk(clk), .reset(reset), .bus(if_lat2)
  );
  mem_responder #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .LATENCY(0)) u_dut_lat0 (
    .clk(clk), .reset(reset), .bus(if_lat0)
  );

  assign if_lat2.req_valid  = req_valid[0];
  assign if_lat2.req_write  = req_write[0];
  assign if_lat2.req_addr   = req_addr[0];
  assign if_lat2.req_wdata  = req_wdata[0];
  assign if_lat2.resp_ready = resp_ready[0];
  assign if_lat0.req_valid  = req_valid[1];
  assign if_lat0.req_write  = req_write[1];
  assign if_lat0.req_addr   = req_addr[1];
  assign if_lat0.req_wdata  = req_wdata[1];
  assign if_lat0.resp_ready = resp_ready[1];

  assign o_ready[0]  = if_lat2.req_ready;
  assign o_valid[0]  = if_lat2.resp_valid;
  assign o_rdata[0]  = if_lat2.resp_rdata;
  assign o_rwrite[0] = if_lat2.resp_write;
  assign o_ready[1]  = if_lat0.req_ready;
  assign o_valid[1]  = if_lat0.resp_valid;
  assign o_rdata[1]  = if_lat0.resp_rdata;
  assign o_rwrite[1] = if_lat0.resp_write;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat [2] = '{2, 0};
  logic [31:0] model   [2][128];
  bit          written [2][128];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int d, input string tag);
    check_eq($sformatf("%s_ready_d%0d", tag, d), {31'd0, o_ready[d]}, 32'd1);
    check_eq($sformatf("%s_valid_d%0d", tag, d), {31'd0, o_valid[d]}, 32'd0);
  endtask

  // One complete transaction; hold>0 keeps resp_ready low for that many cycles
  // and offers an ignored store to address 20 meanwhile.
  task automatic transact(input int d, input bit wr, input logic [6:0] a,
                          input logic [31:0] wd, input int hold);
    logic [31:0] exp_data;
    int n;
    check_eq($sformatf("pre_ready_d%0d", d), {31'd0, o_ready[d]}, 32'd1);
    exp_data      = wr ? wd : model[d][a];
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    resp_ready[d] = (hold == 0);
    tick();
    req_valid[d] = 1'b0;
    if (wr) begin
      model[d][a]   = wd;
      written[d][a] = 1'b1;
    end
    n = 0;
    while (!o_valid[d] && n < 40) begin
      tick();
      n++;
    end
    check_eq($sformatf("resp_delay_d%0d", d), n, lat[d] + 1);
    check_eq($sformatf("rdata_d%0d_a%0d", d, a), o_rdata[d], exp_data);
    check_eq($sformatf("rwrite_d%0d", d), {31'd0, o_rwrite[d]}, {31'd0, wr});
    check_eq($sformatf("busy_ready_d%0d", d), {31'd0, o_ready[d]}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        req_valid[d] = 1'b1;
        req_write[d] = 1'b1;
        req_addr[d]  = 7'd20;
        req_wdata[d] = ~model[d][20];
      end
      tick();
      check_eq($sformatf("bp_valid_d%0d", d), {31'd0, o_valid[d]}, 32'd1);
      check_eq($sformatf("bp_rdata_d%0d", d), o_rdata[d], exp_data);
      check_eq($sformatf("bp_ready_d%0d", d), {31'd0, o_ready[d]}, 32'd0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    tick();
    check_idle(d, "post_resp");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Store that is cut off by reset k cycles after its accept edge.
  task automatic reset_during(input int d, input logic [6:0] a, input logic [31:0] wd, input int k);
    bit seen;
    req_valid[d] = 1'b1;
    req_write[d] = 1'b1;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    tick();
    req_valid[d] = 1'b0;
    repeat (k) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle(d, "rst_mid");
    check_eq($sformatf("rst_mid_rdata_d%0d", d), o_rdata[d], 32'd0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (o_valid[d]) seen = 1'b1;
    end
    check_eq($sformatf("rst_no_resp_d%0d", d), {31'd0, seen}, 32'd0);
    transact(d, 1'b0, a, 32'd0, 0);
  endtask

  task automatic back_to_back(input int d, input logic [6:0] a1, input logic [6:0] a2,
                              input logic [31:0] da, input logic [31:0] db);
    bit          wr_l [4];
    logic [6:0]  ad_l [4];
    logic [31:0] wd_l [4];
    logic [31:0] expq [$];
    int          acc_cyc [4];
    int          nacc, nresp, cyc;
    bit          pend;
    wr_l = '{1'b1, 1'b0, 1'b1, 1'b0};
    ad_l = '{a1, a1, a2, a2};
    wd_l = '{da, 32'd0, db, 32'd0};
    nacc = 0; nresp = 0; cyc = 0;
    resp_ready[d] = 1'b1;
    req_valid[d]  = 1'b1;
    req_write[d]  = wr_l[0];
    req_addr[d]   = ad_l[0];
    req_wdata[d]  = wd_l[0];
    while (cyc < 200 && (nacc < 4 || nresp < 4)) begin
      pend = req_valid[d] && o_ready[d];
      tick();
      cyc++;
      if (pend) begin
        acc_cyc[nacc] = cyc;
        if (wr_l[nacc]) begin
          model[d][ad_l[nacc]]   = wd_l[nacc];
          written[d][ad_l[nacc]] = 1'b1;
        end
        expq.push_back(model[d][ad_l[nacc]]);
        nacc++;
        if (nacc < 4) begin
          req_write[d] = wr_l[nacc];
          req_addr[d]  = ad_l[nacc];
          req_wdata[d] = wd_l[nacc];
        end else begin
          req_valid[d] = 1'b0;
        end
      end
      if (o_valid[d]) begin
        if (expq.size() == 0) begin
          check_eq($sformatf("b2b_extra_resp_d%0d", d), 32'd1, 32'd0);
        end else begin
          check_eq($sformatf("b2b_rdata_d%0d_%0d", d, nresp), o_rdata[d], expq.pop_front());
        end
        nresp++;
      end
    end
    req_valid[d] = 1'b0;
    check_eq($sformatf("b2b_accepts_d%0d", d), nacc, 4);
    check_eq($sformatf("b2b_resps_d%0d", d), nresp, 4);
    for (int i = 1; i < nacc; i++) begin
      check_eq($sformatf("b2b_spacing_d%0d_%0d", d, i), acc_cyc[i] - acc_cyc[i-1], lat[d] + 3);
    end
    tick();
  endtask

  task automatic random_run(input int d, input int n);
    logic [6:0]  a;
    logic [31:0] wd;
    bit          wr;
    for (int i = 0; i < n; i++) begin
      a  = 7'($urandom_range(0, 127));
      wd = $urandom;
      wr = ($urandom_range(0, 1) == 1) || !written[d][a];
      transact(d, wr, a, wd, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 128; a++) written[d][a] = 1'b0;
    end
    do_reset();
    for (int d = 0; d < 2; d++) begin
      check_idle(d, "reset");
      check_eq($sformatf("reset_rdata_d%0d", d), o_rdata[d], 32'd0);
      check_eq($sformatf("reset_rwrite_d%0d", d), {31'd0, o_rwrite[d]}, 32'd0);
    end

    // LATENCY=2: store/load, then backpressure with an ignored request.
    transact(0, 1'b1, 7'd5, 32'hDEADBEEF, 0);
    transact(0, 1'b0, 7'd5, 32'd0, 0);
    transact(0, 1'b1, 7'd20, 32'h2020_2020, 0);
    transact(1, 1'b1, 7'd20, 32'h0BAD_F00D, 0);
    transact(0, 1'b0, 7'd5, 32'd0, 6);
    transact(0, 1'b0, 7'd20, 32'd0, 0);

    // LATENCY=0: top and bottom addresses are distinct words.
    transact(1, 1'b1, 7'd127, 32'h1, 0);
    transact(1, 1'b0, 7'd127, 32'd0, 0);
    transact(1, 1'b1, 7'd0, 32'h2, 0);
    transact(1, 1'b0, 7'd127, 32'd0, 0);
    transact(1, 1'b0, 7'd0, 32'd0, 3);
    transact(1, 1'b0, 7'd20, 32'd0, 0);

    // Reset during WAIT and on the access edge itself.
    transact(0, 1'b1, 7'd9, 32'h55, 0);
    reset_during(0, 7'd9, 32'hAA, 1);
    reset_during(0, 7'd9, 32'hBB, 2);
    transact(1, 1'b1, 7'd9, 32'h33, 0);
    reset_during(1, 7'd9, 32'hCC, 0);
    transact(0, 1'b0, 7'd5, 32'd0, 0);

    back_to_back(0, 7'd40, 7'd41, 32'h1111_0001, 32'h2222_0002);
    back_to_back(1, 7'd42, 7'd43, 32'h3333_0003, 32'h4444_0004);

    random_run(0, 24);
    random_run(1, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the pipelined CPU's data port. It accepts one load or store request at a time through a valid/ready handshake, inserts a programmable number of wait states, and performs the access on an internal word-addressed array. It returns the result through a valid/ready response channel. It replaces the zero-wait data memory behind the MEM stage, so that the pipeline's stall logic can be exercised against realistic memory latency.

## Interface
Parameters:
- ADDR_WIDTH, 7, word-address width; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width
- LATENCY, 2, wait states between acceptance and access; legal range 0..15

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  store data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  DATA_WIDTH  load data (for a store: the data written)
- resp_write  out  1  echo of the latched req_write

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch write/addr/wdata, load the wait counter with LATENCY, and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter nonzero: decrement.
  - Counter == 0:
    - Perform the access at this edge. Store: array[addr] <= wdata, and resp_rdata <= wdata. Load: resp_rdata <= array[addr].
    - Go to RESP.
- RESP:
  - resp_valid=1, with resp_rdata and resp_write held stable.
  - On resp_ready: go to IDLE.
  - Otherwise remain in RESP indefinitely.
- At most one outstanding request. Requests presented outside IDLE are ignored, not queued. The requester must hold req_* stable until req_ready is seen.
- LATENCY=0: WAIT lasts exactly one cycle (the access cycle).
- Addresses wrap naturally at DEPTH. No misalignment or out-of-range checks exist, because the address is word-granular.
- Reset:
  - Sets state to IDLE, counter to 0, resp_valid=0, resp_rdata=0, resp_write=0; req_ready=1 in the first cycle after reset.
  - Does not clear the array.
  - A store caught in WAIT before its access edge is discarded.
  - A store whose access edge coincides with the reset edge is also discarded: reset has priority over every other action.
- A load from a never-written word returns X in simulation. The bench must initialise any words it reads.

## Timing
- Accept edge = T.
- The access occurs at edge T+LATENCY+1.
- resp_valid is high from edge T+LATENCY+1 until the edge where resp_ready=1 is sampled.
- resp_ready held high: resp_valid lasts exactly 1 cycle, and IDLE (req_ready=1) follows for at least 1 cycle.
- Minimum request-to-request spacing is LATENCY+3 cycles.
- req_ready and resp_valid are decoded from state only (no combinational path from inputs).
- A read-after-write to the same address in consecutive requests returns the new data.

## Structure
- Shared package:
  - state encoding constants IDLE=2'b00, WAIT=2'b01, RESP=2'b10 (2'b11 is illegal and returns to IDLE)
  - LATENCY_MAX=15
  - counter width constant CNT_W=4
- One sub-module, mem_array: DEPTH×DATA_WIDTH storage with synchronous write enable and combinational read. The FSM, counter and response register live in mem_responder.

## Test plan
- Reset, then idle: req_ready=1, resp_valid=0, resp_rdata=0 on the first post-reset cycle.
- Store 0xDEADBEEF to addr 5 with LATENCY=2 and resp_ready=1 → resp_valid for exactly 1 cycle at accept+3 with resp_write=1 and resp_rdata=0xDEADBEEF. A subsequent load of addr 5 returns 0xDEADBEEF at its accept+3.
- Backpressure: load with resp_ready=0 for 6 cycles → resp_valid and resp_rdata stay constant and req_ready stays 0. A second request offered meanwhile is ignored. resp_ready=1 → IDLE next cycle.
- LATENCY=0 build: store 0x1 to addr 127, then load addr 127 → each response arrives at accept+1; address 127 and address 0 remain distinct words (store 0x2 to addr 0, and addr 127 still reads 0x1).
- Reset mid-operation: addr 9 holds 0x55. Store 0xAA to addr 9, then assert reset while in WAIT (counter=1) → no response; a later load of addr 9 returns 0x55.
- Back-to-back: 4 alternating stores and loads with req_valid held high continuously → exactly 4 acceptances, spaced LATENCY+3 cycles apart, each with correct data.
